// File: rtl/pixel_unpacker_if.sv
// Packed 32-bit video stream as produced by the pixel packer.
// The master drives the payload, the slave returns tready.
interface pixel_unpacker_if;
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tlast;
    logic        tuser;
    logic        tvalid;
    logic        tready;

    modport master (output tdata, tkeep, tlast, tuser, tvalid, input tready);
    modport slave  (input tdata, tkeep, tlast, tuser, tvalid, output tready);
endinterface

// File: rtl/pixel_unpacker.sv
// Rebuilds one 24-bit RGB pixel per handshake from the packed 3-words-per-4-pixels stream,
// restoring sof/eol markers and flagging misplaced tuser/tlast.
module pixel_unpacker #(
    parameter int X_SIZE = 640
) (
    input  logic              aclk,
    input  logic              aresetn,
    pixel_unpacker_if.slave   in_stream,
    output logic [7:0]        r,
    output logic [7:0]        g,
    output logic [7:0]        b,
    output logic              sof,
    output logic              eol,
    output logic              valid,
    input  logic              ready,
    output logic              err_sof,
    output logic              err_line,
    input  logic              err_clear
);
    localparam int W_LINE = 3 * X_SIZE / 4;
    localparam int PW     = $clog2(X_SIZE);
    localparam int WW     = $clog2(W_LINE);

    // State number equals the count of residual bytes held over from the last word.
    typedef enum logic [1:0] {S0, S1, S2, S3} state_t;

    state_t        r_state;
    logic [23:0]   r_res;
    logic [PW-1:0] r_pcnt;
    logic [WW-1:0] r_wcnt;

    logic          w_load, w_tready, w_beat, w_resync, w_early, w_wlast, w_pc_last, w_hold_last;
    state_t        w_eff, w_st_nxt;
    logic [PW-1:0] w_pc, w_pc_nxt;
    logic [WW-1:0] w_wc, w_wc_nxt;
    logic [23:0]   w_pix, w_res_nxt;
    logic          w_unused_tkeep;

    assign w_unused_tkeep  = ^in_stream.tkeep;
    assign w_load          = !valid || ready;
    assign w_tready        = aresetn && w_load && (r_state != S3);
    assign in_stream.tready = w_tready;
    assign w_beat          = in_stream.tvalid && w_tready;

    always_comb begin
        // A tuser beat mid-group restarts the group: drop residual, restart counters.
        w_resync    = in_stream.tuser && (r_state == S1 || r_state == S2);
        w_eff       = w_resync ? S0 : r_state;
        w_pc        = w_resync ? '0 : r_pcnt;
        w_wc        = w_resync ? '0 : r_wcnt;
        w_wlast     = (w_wc == WW'(W_LINE - 1));
        w_early     = in_stream.tlast && !w_wlast;
        w_pc_last   = (w_pc == PW'(X_SIZE - 1));
        w_pc_nxt    = (w_early || w_pc_last) ? '0 : w_pc + PW'(1);
        w_wc_nxt    = (w_early || w_wlast) ? '0 : w_wc + WW'(1);
        w_hold_last = (r_pcnt == PW'(X_SIZE - 1));
        w_pix       = r_res;
        w_res_nxt   = r_res;
        w_st_nxt    = S3;
        case (w_eff)
            S0: begin
                w_pix     = in_stream.tdata[23:0];
                w_res_nxt = {16'h0, in_stream.tdata[31:24]};
                w_st_nxt  = S1;
            end
            S1: begin
                w_pix     = {in_stream.tdata[15:0], r_res[7:0]};
                w_res_nxt = {8'h0, in_stream.tdata[31:16]};
                w_st_nxt  = S2;
            end
            S2: begin
                w_pix     = {in_stream.tdata[7:0], r_res[15:0]};
                w_res_nxt = in_stream.tdata[31:8];
                w_st_nxt  = S3;
            end
            default: ;
        endcase
        if (w_early) w_st_nxt = S0;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state  <= S0;
            r_res    <= '0;
            r_pcnt   <= '0;
            r_wcnt   <= '0;
            valid    <= 1'b0;
            sof      <= 1'b0;
            eol      <= 1'b0;
            r        <= '0;
            g        <= '0;
            b        <= '0;
            err_sof  <= 1'b0;
            err_line <= 1'b0;
        end else begin
            // Clear first so that a same-cycle error below takes priority.
            if (err_clear) begin
                err_sof  <= 1'b0;
                err_line <= 1'b0;
            end
            if (w_beat) begin
                if (w_resync) err_sof <= 1'b1;
                if (in_stream.tlast != w_wlast) err_line <= 1'b1;
                valid       <= 1'b1;
                {r, g, b}   <= w_pix;
                sof         <= in_stream.tuser;
                eol         <= !w_early && w_pc_last;
                r_pcnt      <= w_pc_nxt;
                r_wcnt      <= w_wc_nxt;
                r_res       <= w_res_nxt;
                r_state     <= w_st_nxt;
            end else if (r_state == S3 && w_load) begin
                valid       <= 1'b1;
                {r, g, b}   <= r_res;
                sof         <= 1'b0;
                eol         <= w_hold_last;
                r_pcnt      <= w_hold_last ? '0 : r_pcnt + PW'(1);
                r_state     <= S0;
            end else if (w_load) begin
                valid       <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_pixel_unpacker.sv
// Randomized bench for pixel_unpacker against a byte-queue reference of the packing format.
module tb_pixel_unpacker;
    localparam int X = 640;
    localparam int W = 3 * X / 4;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    pixel_unpacker_if bus();
    logic [7:0] r, g, b;
    logic sof, eol, valid, ready, err_sof, err_line, err_clear;

    pixel_unpacker #(.X_SIZE(X)) dut (
        .aclk(aclk), .aresetn(aresetn), .in_stream(bus.slave),
        .r(r), .g(g), .b(b), .sof(sof), .eol(eol), .valid(valid), .ready(ready),
        .err_sof(err_sof), .err_line(err_line), .err_clear(err_clear)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: stream bytes LSB first, each pixel is 3 bytes (b,g,r).
    logic [7:0]  bq[$];
    logic [25:0] pq[$];
    int m_pc, m_wc, sof_seen, eol_seen;
    bit m_esof, m_eline;

    function automatic void model_clear();
        bq.delete(); pq.delete();
        m_pc = 0; m_wc = 0; m_esof = 0; m_eline = 0;
        sof_seen = 0; eol_seen = 0;
    endfunction

    function automatic void emit(bit s, bit e);
        logic [7:0] pb, pg, pr;
        pb = bq.pop_front(); pg = bq.pop_front(); pr = bq.pop_front();
        pq.push_back({pr, pg, pb, s, e});
    endfunction

    function automatic void model_word(logic [31:0] d, bit u, bit l);
        bit last_w, early;
        if (u && bq.size() != 0) begin
            bq.delete(); m_esof = 1; m_pc = 0; m_wc = 0;
        end
        for (int i = 0; i < 4; i++) bq.push_back(d[8*i +: 8]);
        last_w = (m_wc == W - 1);
        early  = l && !last_w;
        if (l != last_w) m_eline = 1;
        emit(u, !early && m_pc == X - 1);
        m_pc = early ? 0 : (m_pc + 1) % X;
        m_wc = early ? 0 : (m_wc + 1) % W;
        if (early) bq.delete();
        else if (bq.size() == 3) begin
            emit(0, m_pc == X - 1);
            m_pc = (m_pc + 1) % X;
        end
    endfunction

    // Monitor: the values seen at the falling edge are what the next rising edge acts on.
    always @(negedge aclk) begin
        if (aresetn) begin
            if (valid && ready) begin
                check("sb_avail", 32'(pq.size() != 0), 32'd1);
                if (pq.size() != 0) check("pixel", {6'h0, r, g, b, sof, eol}, {6'h0, pq.pop_front()});
                if (sof) sof_seen++;
                if (eol) eol_seen++;
            end
            if (err_clear) begin m_esof = 0; m_eline = 0; end
            if (bus.tvalid && bus.tready) model_word(bus.tdata, bus.tuser, bus.tlast);
        end
    end

    // Ready pattern: 0 high, 1 toggle, 2 random, 3 follow rman.
    int rmode = 0;
    logic rman = 1'b1;
    always @(posedge aclk) begin
        #1;
        case (rmode)
            0: ready = 1'b1;
            1: ready = !ready;
            2: ready = 1'($urandom_range(0, 1));
            default: ready = rman;
        endcase
    end

    task automatic send_word(input logic [31:0] d, input bit u, input bit l, input int gap);
        int n;
        bus.tvalid = 1'b0;
        repeat (gap) begin @(posedge aclk); #1; end
        bus.tdata = d; bus.tuser = u; bus.tlast = l; bus.tvalid = 1'b1;
        n = 0;
        forever begin
            @(negedge aclk);
            if (bus.tready) break;
            n++;
            if (n > 500) begin check("accept_timeout", 32'(bus.tready), 32'd1); break; end
        end
        @(posedge aclk); #1;
        bus.tvalid = 1'b0; bus.tuser = 1'b0; bus.tlast = 1'b0;
    endtask

    task automatic send_line(input bit first, input int nwords, input int tl_at, input int gmax);
        for (int w = 0; w < nwords; w++)
            send_word($urandom, first && w == 0, w == tl_at, $urandom_range(0, gmax));
    endtask

    task automatic drain();
        repeat (20) begin @(posedge aclk); #1; end
        check("drain_empty", 32'(pq.size()), 32'd0);
    endtask

    task automatic chk_flags();
        @(posedge aclk); #2;
        check("err_sof", 32'(err_sof), 32'(m_esof));
        check("err_line", 32'(err_line), 32'(m_eline));
    endtask

    task automatic do_reset();
        @(posedge aclk); #1;
        aresetn = 1'b0;
        model_clear();
        repeat (2) begin @(posedge aclk); #1; end
        aresetn = 1'b1;
    endtask

    logic [31:0] dw [3];
    logic [23:0] dp [4];

    initial begin
        dw = '{32'h44332211, 32'h88776655, 32'hCCBBAA99};
        dp = '{24'h332211, 24'h665544, 24'h998877, 24'hCCBBAA};
        bus.tdata = '0; bus.tkeep = 4'hF; bus.tlast = 0; bus.tuser = 0; bus.tvalid = 0;
        ready = 1'b1; err_clear = 1'b0;
        model_clear();

        // Reset state
        #12;
        check("rst_valid", 32'(valid), 0);
        check("rst_tready", 32'(bus.tready), 0);
        check("rst_pix", {6'h0, r, g, b, sof, eol}, 0);
        check("rst_err", {30'h0, err_sof, err_line}, 0);
        @(posedge aclk); #1; aresetn = 1'b1;

        // Directed decode of one pixel group
        for (int i = 0; i < 4; i++) begin
            if (i < 3) begin bus.tvalid = 1; bus.tdata = dw[i]; end
            else bus.tvalid = 0;
            @(negedge aclk);
            check(i < 3 ? "dec_tready" : "dec_tready_s3", 32'(bus.tready), i < 3 ? 1 : 0);
            if (i > 0) begin
                check("dec_valid", 32'(valid), 1);
                check("dec_pix", {8'h0, r, g, b}, {8'h0, dp[i-1]});
            end
            @(posedge aclk); #1;
        end
        @(negedge aclk);
        check("dec_valid", 32'(valid), 1);
        check("dec_pix", {8'h0, r, g, b}, {8'h0, dp[3]});
        drain();

        // Full frame: three well-formed lines
        do_reset();
        for (int l = 0; l < 3; l++) send_line(l == 0, W, W - 1, 0);
        drain();
        check("frame_sof_cnt", sof_seen, 1);
        check("frame_eol_cnt", eol_seen, 3);
        chk_flags();

        // Backpressure with toggling then random ready and random tvalid gaps
        do_reset();
        rmode = 1;
        for (int l = 0; l < 2; l++) send_line(l == 0, W, W - 1, 2);
        rmode = 2;
        send_line(0, W, W - 1, 3);
        rmode = 0;
        drain();
        check("bp_eol_cnt", eol_seen, 3);
        chk_flags();

        // Early tlast on word 100
        do_reset();
        send_line(1, 101, 100, 0);
        send_line(0, 6, -1, 0);
        drain();
        check("early_eol_cnt", eol_seen, 0);
        check("early_err_line", 32'(err_line), 1);
        chk_flags();

        // tuser on the second word of a group, then err_clear
        do_reset();
        send_word($urandom, 1, 0, 0);
        send_word($urandom, 1, 0, 0);
        send_line(0, 5, -1, 1);
        drain();
        check("mis_err_sof", 32'(err_sof), 1);
        check("mis_sof_cnt", sof_seen, 2);
        chk_flags();
        @(posedge aclk); #1; err_clear = 1'b1;
        @(posedge aclk); #1; err_clear = 1'b0;
        check("clr_err_sof", 32'(err_sof), 0);
        chk_flags();

        // Reset while parked in S3 with a stalled pixel
        do_reset();
        rmode = 3; rman = 1'b1;
        send_word(dw[0], 0, 0, 0);
        send_word(dw[1], 0, 0, 0);
        bus.tdata = dw[2]; bus.tvalid = 1;
        @(negedge aclk);
        check("s3_setup_tready", 32'(bus.tready), 1);
        rman = 1'b0;
        @(posedge aclk); #1; bus.tvalid = 0;
        @(negedge aclk);
        check("s3_valid", 32'(valid), 1);
        check("s3_tready", 32'(bus.tready), 0);
        @(negedge aclk);
        check("s3_hold_pix", {8'h0, r, g, b}, {8'h0, dp[2]});
        @(posedge aclk); #1;
        aresetn = 1'b0;
        model_clear();
        #1;
        check("mid_rst_valid", 32'(valid), 0);
        check("mid_rst_tready", 32'(bus.tready), 0);
        repeat (2) begin @(posedge aclk); #1; end
        aresetn = 1'b1; rman = 1'b1;
        for (int i = 0; i < 3; i++) send_word(dw[i], 0, 0, 0);
        drain();
        chk_flags();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
